// File: rtl/bnn_pkg.sv
// Shared types and defaults for the sequential binary layer.
// Pure declarations; no timing or flow control of its own.
package bnn_pkg;

  localparam int INPUT_SIZE_DEF  = 784;
  localparam int NUM_NEURONS_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } bnn_seq_state_e;

  function automatic int idx_width(input int num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

endpackage

// File: rtl/bnn_layer_seq_if.sv
// Activation, weight-memory and result channels of the sequential layer.
// valid/ready on input and output; memory read returns one cycle after rd_en.
interface bnn_layer_seq_if
  import bnn_pkg::*;
#(
  parameter int INPUT_SIZE      = INPUT_SIZE_DEF,
  parameter int NUM_NEURONS     = NUM_NEURONS_DEF,
  parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1),
  parameter int IDX_WIDTH       = idx_width(NUM_NEURONS)
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [INPUT_SIZE-1:0]      in_vec;

  logic                       mem_rd_en;
  logic [IDX_WIDTH-1:0]       mem_addr;
  logic [INPUT_SIZE-1:0]      mem_weight;
  logic [THRESHOLD_WIDTH-1:0] mem_threshold;

  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_NEURONS-1:0]     out_vec;

  logic                       busy;

  modport master (
    input  in_valid, in_vec, mem_weight, mem_threshold, out_ready,
    output in_ready, mem_rd_en, mem_addr, out_valid, out_vec, busy
  );

  modport slave (
    output in_valid, in_vec, mem_weight, mem_threshold, out_ready,
    input  in_ready, mem_rd_en, mem_addr, out_valid, out_vec, busy
  );

endinterface

// File: rtl/bnn_layer_seq_neuron.sv
// XNOR-popcount binary neuron: out = popcount(~(in ^ w)) >= threshold, unsigned.
// Purely combinational; no flow control.
module MLP_Neuron #(
  parameter int INPUT_SIZE      = 784,
  parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1)
) (
  input  logic [INPUT_SIZE-1:0]      in_vec,
  input  logic [INPUT_SIZE-1:0]      weight,
  input  logic [THRESHOLD_WIDTH-1:0] threshold,
  output logic                       out
);

  logic [INPUT_SIZE-1:0]      match;
  logic [THRESHOLD_WIDTH-1:0] pop;

  assign match = ~(in_vec ^ weight);

  // THRESHOLD_WIDTH holds INPUT_SIZE exactly, so the count cannot wrap.
  always_comb begin
    pop = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      pop = pop + THRESHOLD_WIDTH'(match[i]);
    end
  end

  assign out = (pop >= threshold);

endmodule

// File: rtl/bnn_layer_seq.sv
// Sequential binary layer: one shared neuron evaluates NUM_NEURONS rows fetched from weight memory.
// Result valid 3*NUM_NEURONS cycles after accept; held in DONE until out_ready, input stalled while busy.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter int INPUT_SIZE      = INPUT_SIZE_DEF,
  parameter int NUM_NEURONS     = NUM_NEURONS_DEF,
  parameter int THRESHOLD_WIDTH = $clog2(INPUT_SIZE + 1),
  parameter int IDX_WIDTH       = idx_width(NUM_NEURONS)
) (
  input logic              clk,
  input logic              rst,
  bnn_layer_seq_if.master  io
);

  bnn_seq_state_e             state;
  bnn_seq_state_e             state_nxt;
  logic [IDX_WIDTH-1:0]       idx;
  logic [INPUT_SIZE-1:0]      in_q;
  logic [INPUT_SIZE-1:0]      w_q;
  logic [THRESHOLD_WIDTH-1:0] t_q;
  logic [NUM_NEURONS-1:0]     out_vec;
  logic                       neuron_out;
  logic                       last_idx;

  assign last_idx = (idx == IDX_WIDTH'(NUM_NEURONS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.in_valid) state_nxt = FETCH;
      FETCH:   state_nxt = LATCH;
      LATCH:   state_nxt = EVAL;
      EVAL:    state_nxt = last_idx ? DONE : FETCH;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      in_q    <= '0;
      w_q     <= '0;
      t_q     <= '0;
      out_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            in_q    <= io.in_vec;
            idx     <= '0;
            out_vec <= '0;
          end
        end
        LATCH: begin
          w_q <= io.mem_weight;
          t_q <= io.mem_threshold;
        end
        EVAL: begin
          out_vec[idx] <= neuron_out;
          if (!last_idx) idx <= idx + IDX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Operands come straight from flops so the popcount tree is the whole EVAL path.
  MLP_Neuron #(
    .INPUT_SIZE      (INPUT_SIZE),
    .THRESHOLD_WIDTH (THRESHOLD_WIDTH)
  ) u_neuron (
    .in_vec    (in_q),
    .weight    (w_q),
    .threshold (t_q),
    .out       (neuron_out)
  );

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state == FETCH) || (state == LATCH) || (state == EVAL);
  assign io.mem_rd_en = (state == FETCH);
  assign io.mem_addr  = (state == FETCH) ? idx : '0;
  assign io.out_vec   = out_vec;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq with 8-bit inputs, 4 neurons and a one-cycle weight memory.
module tb_bnn_layer_seq;
  import bnn_pkg::*;

  localparam int IS = 8;
  localparam int NN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [IS-1:0] mem_w [NN];
  logic [3:0]    mem_t [NN];
  logic [1:0]    addr_q [$];

  bnn_layer_seq_if #(.INPUT_SIZE(IS), .NUM_NEURONS(NN)) bus ();

  bnn_layer_seq #(.INPUT_SIZE(IS), .NUM_NEURONS(NN)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  // Weight memory: data for the addressed row one cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_weight    <= mem_w[bus.mem_addr];
      bus.mem_threshold <= mem_t[bus.mem_addr];
    end else begin
      bus.mem_weight    <= 8'h5A;
      bus.mem_threshold <= 4'hC;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.mem_rd_en) addr_q.push_back(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rows(input logic [31:0] w, input logic [15:0] t);
    for (int i = 0; i < NN; i++) begin
      mem_w[i] = w[8*i +: 8];
      mem_t[i] = t[4*i +: 4];
    end
  endtask

  // Starts from IDLE at a negedge, ends at the negedge where out_valid is seen.
  task automatic do_frame(input logic [7:0] v, input logic [3:0] exp, input string tag,
                          input bit release_out);
    int n;
    int base;
    base = addr_q.size();
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      bus.in_vec = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 12);
    chk({tag, "_out_vec"}, 32'(bus.out_vec), 32'(exp));
    chk({tag, "_rd_count"}, addr_q.size() - base, 4);
    for (int i = 0; i < NN; i++) begin
      if (base + i < addr_q.size()) chk({tag, "_addr"}, 32'(addr_q[base + i]), i);
    end
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 1);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] held;
    logic [7:0] vecs [4];
    logic [3:0] exps [3];
    int acc [3];
    int n;
    int base;

    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    set_rows(32'h0F0F_00FF, 16'h5418);

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_rd_en",     32'(bus.mem_rd_en), 0);
    chk("rst_addr",      32'(bus.mem_addr), 0);
    chk("rst_out_vec",   32'(bus.out_vec), 0);
    rst = 1'b0;
    @(negedge clk);

    do_frame(8'hFF, 4'b0101, "basic", 1'b1);

    set_rows(32'hA5A5_A5A5, 16'hF980);
    do_frame(8'hA5, 4'b0011, "thresh", 1'b1);

    // Third pattern, then hold it in DONE under backpressure.
    set_rows(32'hFF30_3CC3, 16'h5680);
    do_frame(8'h3C, 4'b0111, "mixed", 1'b0);
    held = bus.out_vec;
    base = addr_q.size();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in_vec   = 8'h00;
      @(negedge clk);
      chk("bp_out_vec",   32'(bus.out_vec), 32'(held));
      chk("bp_in_ready",  32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_rel_in_ready",  32'(bus.in_ready), 1);
    chk("bp_rel_out_valid", 32'(bus.out_valid), 0);
    chk("bp_no_reads",      addr_q.size() - base, 0);

    // Reset in the EVAL cycle of neuron 2.
    set_rows(32'h0F0F_00FF, 16'h5418);
    bus.in_valid = 1'b1;
    bus.in_vec   = 8'hFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_state_eval", 32'(dut.state), 32'(EVAL));
    chk("mid_idx",        32'(dut.idx), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_out_vec",   32'(bus.out_vec), 0);
    chk("mid_state",     32'(dut.state), 32'(IDLE));
    chk("mid_in_ready",  32'(bus.in_ready), 1);
    chk("mid_busy",      32'(bus.busy), 0);
    do_frame(8'h0F, 4'b1110, "post_rst", 1'b1);

    // Back-to-back frames with in_valid and out_ready held high.
    vecs[0] = 8'hFF; vecs[1] = 8'h00; vecs[2] = 8'h0F; vecs[3] = 8'h00;
    exps[0] = 4'b0101; exps[1] = 4'b0110; exps[2] = 4'b1110;
    base = addr_q.size();
    n = 0;
    bus.in_vec    = vecs[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      while (!bus.busy && n < 1000) begin @(negedge clk); n++; end
      acc[f] = n;
      if (f < 2) bus.in_vec = vecs[f + 1];
      else       bus.in_valid = 1'b0;
      while (!bus.out_valid && n < 1000) begin @(negedge clk); n++; end
      chk("b2b_latency", n - acc[f], 12);
      chk("b2b_out_vec", 32'(bus.out_vec), 32'(exps[f]));
      if (f > 0) chk("b2b_period", acc[f] - acc[f - 1], 14);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("b2b_rd_count", addr_q.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < addr_q.size()) chk("b2b_addr", 32'(addr_q[base + i]), i % 4);
    end
    chk("b2b_end_in_ready", 32'(bus.in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
